fpu_issue_controller: RTL and testbench

- Sits directly upstream of the fixed-point unit, between the execute-stage dispatch and the FPU.
- Queues tagged FPU requests from dispatch and presents one request at a time to the FPU, holding operands and operation stable.
- Waits for the FPU's ready, captures the result, and returns it through a writeback valid/ready handshake.
- Guards against a stuck FPU with a timeout and inserts a settle cycle so the FPU's internal multiply/sqrt FSMs return to idle.

---
 rtl/fpu_issue_controller_pkg.sv | 30 +++
 rtl/fpu_issue_controller_fifo.sv | 61 ++++++
 rtl/fpu_issue_controller.sv | 154 +++++++++++++++
 tb/tb_fpu_issue_controller.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_controller_pkg.sv
//------------------------------------------------------------------------------
// Module      : fpu_issue_controller_pkg
// Description : FPU operation codes, issue-FSM state type and default timeout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package fpu_issue_controller_pkg;

    typedef enum logic [1:0] {
        FPU_ADD  = 2'd0,
        FPU_SUB  = 2'd1,
        FPU_MUL  = 2'd2,
        FPU_SQRT = 2'd3
    } fpu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESPOND = 3'd3,
        ST_SETTLE  = 3'd4
    } issue_state_e;

    localparam int DEFAULT_TIMEOUT = 64;

endpackage

`default_nettype wire

// File: rtl/fpu_issue_controller_fifo.sv
//------------------------------------------------------------------------------
// Module      : fpu_request_fifo
// Description : DEPTH-entry synchronous request FIFO with registered count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fpu_request_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full      = (r_count == (c_PTR_W+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push    = push && !full;
    assign w_pop     = pop && !empty;
    assign head_data = r_mem[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/fpu_issue_controller.sv
//------------------------------------------------------------------------------
// Module      : fpu_issue_controller
// Description : Queues tagged FPU requests, issues one at a time, returns results.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fpu_issue_controller
    import fpu_issue_controller_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 5,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_operand_1,
    input  logic [WIDTH-1:0] req_operand_2,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_result,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_error,
    output logic             busy
);

    localparam int c_DATA_W  = 2 + 2*WIDTH + TAG_W;
    localparam int c_TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);

    issue_state_e         r_state;
    issue_state_e         w_state_next;
    fpu_op_e              r_op;
    logic [WIDTH-1:0]     r_operand_1;
    logic [WIDTH-1:0]     r_operand_2;
    logic [TAG_W-1:0]     r_tag;
    logic [c_TIMER_W-1:0] r_timer;
    logic [WIDTH-1:0]     r_wb_result;
    logic                 r_wb_error;
    logic [c_DATA_W-1:0]  w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drive;
    logic                 w_timeout;

    assign req_ready = !w_full;
    assign w_push    = req_valid && req_ready;
    assign w_pop     = wb_valid && wb_ready;
    assign w_timeout = (r_timer == c_TIMER_LAST);

    // The in-flight request stays at the head until its writeback completes.
    fpu_request_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (c_DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({req_op, req_operand_1, req_operand_2, req_tag}),
        .pop       (w_pop),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_drive      = 1'b0;
        case (r_state)
            ST_IDLE:    if (!w_empty) w_state_next = ST_ISSUE;
            ST_ISSUE: begin
                w_drive      = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_drive = 1'b1;
                if (fpu_ready || w_timeout) w_state_next = ST_RESPOND;
            end
            ST_RESPOND: begin
                w_drive = 1'b1;
                if (wb_ready) w_state_next = ST_SETTLE;
            end
            ST_SETTLE:  w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // ISSUE ignores fpu_ready since it may still reflect the previous operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op        <= FPU_ADD;
            r_operand_1 <= '0;
            r_operand_2 <= '0;
            r_tag       <= '0;
            r_timer     <= '0;
            r_wb_result <= '0;
            r_wb_error  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_op        <= fpu_op_e'(w_head[c_DATA_W-1 -: 2]);
                        r_operand_1 <= w_head[TAG_W+WIDTH +: WIDTH];
                        r_operand_2 <= w_head[TAG_W +: WIDTH];
                        r_tag       <= w_head[TAG_W-1:0];
                    end
                end
                ST_ISSUE: r_timer <= '0;
                ST_WAIT: begin
                    if (fpu_ready) begin
                        r_wb_result <= fpu_result;
                        r_wb_error  <= 1'b0;
                    end else if (w_timeout) begin
                        r_wb_result <= '0;
                        r_wb_error  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fpu_operation = w_drive ? r_op        : FPU_ADD;
    assign fpu_operand_1 = w_drive ? r_operand_1 : '0;
    assign fpu_operand_2 = w_drive ? r_operand_2 : '0;
    assign wb_valid      = (r_state == ST_RESPOND);
    assign wb_result     = r_wb_result;
    assign wb_tag        = r_tag;
    assign wb_error      = r_wb_error;
    assign busy          = (r_state != ST_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_controller.sv
//------------------------------------------------------------------------------
// Module      : tb_fpu_issue_controller
// Description : Directed self-checking bench for fpu_issue_controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fpu_issue_controller;
    import fpu_issue_controller_pkg::*;

    localparam int WIDTH   = 32;
    localparam int TAG_W   = 5;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 8;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_operand_1;
    logic [WIDTH-1:0] req_operand_2;
    logic [TAG_W-1:0] req_tag;
    logic [WIDTH-1:0] fpu_operand_1;
    logic [WIDTH-1:0] fpu_operand_2;
    logic [1:0]       fpu_operation;
    logic [WIDTH-1:0] fpu_result;
    logic             fpu_ready;
    logic             wb_valid;
    logic             wb_ready;
    logic [WIDTH-1:0] wb_result;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_error;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // FPU model: 0 = combinational add/sub, 1 = ready fpu_lat cycles after ISSUE, 2 = never ready
    int          fpu_mode = 0;
    int          fpu_lat  = 0;
    logic [31:0] fpu_res_val = '0;
    int          op_cnt;

    fpu_issue_controller #(
        .WIDTH   (WIDTH),
        .TAG_W   (TAG_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_operand_1 (req_operand_1),
        .req_operand_2 (req_operand_2),
        .req_tag       (req_tag),
        .fpu_operand_1 (fpu_operand_1),
        .fpu_operand_2 (fpu_operand_2),
        .fpu_operation (fpu_operation),
        .fpu_result    (fpu_result),
        .fpu_ready     (fpu_ready),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_result     (wb_result),
        .wb_tag        (wb_tag),
        .wb_error      (wb_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) op_cnt <= 0;
        else if (fpu_operation == FPU_MUL || fpu_operation == FPU_SQRT) op_cnt <= op_cnt + 1;
        else op_cnt <= 0;
    end

    always_comb begin
        fpu_ready  = 1'b0;
        fpu_result = '0;
        case (fpu_mode)
            0: begin
                fpu_ready  = 1'b1;
                fpu_result = (fpu_operation == FPU_SUB) ? fpu_operand_1 - fpu_operand_2
                                                        : fpu_operand_1 + fpu_operand_2;
            end
            1: begin
                fpu_ready  = (op_cnt >= fpu_lat);
                fpu_result = fpu_res_val;
            end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] tag);
        req_valid     = 1'b1;
        req_op        = op;
        req_operand_1 = a;
        req_operand_2 = b;
        req_tag       = tag;
    endtask

    task automatic wait_wb(input int max, output int n);
        n = 0;
        while (!wb_valid && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({req_ready, wb_valid, wb_result, wb_tag, wb_error, busy, fpu_operand_1, fpu_operand_2, fpu_operation}
            !== {1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, FPU_ADD}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%0b v=%0b res=%h tag=%0d err=%0b busy=%0b op=%0d a=%h b=%h, expected 1 0 0 0 0 0 0 0 0",
                     req_ready, wb_valid, wb_result, wb_tag, wb_error, busy, fpu_operation, fpu_operand_1, fpu_operand_2);
        end
        #3 reset = 1'b1;
        tick();
        checks++;
        if ({req_ready, wb_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL after_release: got rdy=%0b v=%0b busy=%0b, expected 1 0 0", req_ready, wb_valid, busy);
        end
    endtask

    task automatic test_single_add();
        fpu_mode = 0;
        drive_req(FPU_ADD, 32'h0000_0C00, 32'h0000_0400, 5'd3);
        tick();
        req_valid = 1'b0;
        tick();
        checks++;
        if ({wb_valid, fpu_operation, fpu_operand_1, fpu_operand_2} !== {1'b0, FPU_ADD, 32'h0C00, 32'h0400}) begin
            errors++;
            $display("FAIL add_issue: got v=%0b op=%0d a=%h b=%h, expected 0 0 00000c00 00000400",
                     wb_valid, fpu_operation, fpu_operand_1, fpu_operand_2);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_early_valid: got v=%0b, expected 0", wb_valid);
        end
        tick();
        checks++;
        if ({wb_valid, wb_result, wb_tag, wb_error} !== {1'b1, 32'h0000_1000, 5'd3, 1'b0}) begin
            errors++;
            $display("FAIL add_wb: got v=%0b res=%h tag=%0d err=%0b, expected 1 00001000 3 0",
                     wb_valid, wb_result, wb_tag, wb_error);
        end
        handshake();
        checks++;
        if ({wb_valid, busy, fpu_operation, fpu_operand_1, fpu_operand_2} !== {1'b0, 1'b1, FPU_ADD, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL add_settle: got v=%0b busy=%0b op=%0d a=%h b=%h, expected 0 1 0 0 0",
                     wb_valid, busy, fpu_operation, fpu_operand_1, fpu_operand_2);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL add_idle_busy: got busy=%0b, expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int n;
        fpu_mode = 0;
        wb_ready = 1'b0;
        drive_req(FPU_SUB, 32'h10, 32'h1, 5'd1);
        tick();
        drive_req(FPU_SUB, 32'h20, 32'h2, 5'd2);
        tick();
        drive_req(FPU_SUB, 32'h30, 32'h3, 5'd3);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got rdy=%0b, expected 0", req_ready);
        end
        wait_wb(20, n);
        checks++;
        if ({wb_valid, wb_result, wb_tag, wb_error, req_ready} !== {1'b1, 32'h0F, 5'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bp_first: got v=%0b res=%h tag=%0d err=%0b rdy=%0b, expected 1 0000000f 1 0 0",
                     wb_valid, wb_result, wb_tag, wb_error, req_ready);
        end
        handshake();
        checks++;
        if ({req_ready, wb_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_after_pop: got rdy=%0b v=%0b, expected 1 0", req_ready, wb_valid);
        end
        tick();
        req_valid = 1'b0;
        wait_wb(20, n);
        checks++;
        if ({wb_valid, wb_result, wb_tag} !== {1'b1, 32'h1E, 5'd2}) begin
            errors++;
            $display("FAIL bp_second: got v=%0b res=%h tag=%0d, expected 1 0000001e 2", wb_valid, wb_result, wb_tag);
        end
        handshake();
        wait_wb(20, n);
        checks++;
        if ({wb_valid, wb_result, wb_tag} !== {1'b1, 32'h2D, 5'd3}) begin
            errors++;
            $display("FAIL bp_third: got v=%0b res=%h tag=%0d, expected 1 0000002d 3", wb_valid, wb_result, wb_tag);
        end
        handshake();
        tick();
    endtask

    task automatic test_mul_latency();
        int n;
        bit held_ok;
        fpu_mode    = 1;
        fpu_lat     = 6;
        fpu_res_val = 32'h0000_0800;
        drive_req(FPU_MUL, 32'h40, 32'h20, 5'd7);
        tick();
        req_valid = 1'b0;
        n = 0;
        held_ok = 1'b1;
        while (!wb_valid && n < 30) begin
            tick();
            n++;
            if (fpu_operation !== FPU_MUL || fpu_operand_1 !== 32'h40 || fpu_operand_2 !== 32'h20) held_ok = 1'b0;
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL mul_hold: operands/op changed during issue, got op=%0d a=%h b=%h, expected 2 00000040 00000020",
                     fpu_operation, fpu_operand_1, fpu_operand_2);
        end
        checks++;
        if ({wb_valid, wb_result, wb_tag, wb_error} !== {1'b1, 32'h800, 5'd7, 1'b0} || n != 8) begin
            errors++;
            $display("FAIL mul_wb: got v=%0b res=%h tag=%0d err=%0b edges=%0d, expected 1 00000800 7 0 8",
                     wb_valid, wb_result, wb_tag, wb_error, n);
        end
        handshake();
        tick();
    endtask

    task automatic test_timeout();
        int n;
        fpu_mode = 2;
        drive_req(FPU_MUL, 32'h5, 32'h6, 5'd4);
        tick();
        drive_req(FPU_ADD, 32'h11, 32'h22, 5'd5);
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!wb_valid && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if ({wb_valid, wb_result, wb_tag, wb_error} !== {1'b1, 32'h0, 5'd4, 1'b1} || n != 10) begin
            errors++;
            $display("FAIL timeout_wb: got v=%0b res=%h tag=%0d err=%0b edges=%0d, expected 1 00000000 4 1 10",
                     wb_valid, wb_result, wb_tag, wb_error, n);
        end
        fpu_mode = 0;
        handshake();
        wait_wb(20, n);
        checks++;
        if ({wb_valid, wb_result, wb_tag, wb_error} !== {1'b1, 32'h33, 5'd5, 1'b0}) begin
            errors++;
            $display("FAIL timeout_next: got v=%0b res=%h tag=%0d err=%0b, expected 1 00000033 5 0",
                     wb_valid, wb_result, wb_tag, wb_error);
        end
        handshake();
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bit saw_valid;
        fpu_mode = 2;
        drive_req(FPU_MUL, 32'h7, 32'h9, 5'd8);
        tick();
        drive_req(FPU_ADD, 32'h1, 32'h1, 5'd9);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({fpu_operation, busy, req_ready} !== {FPU_MUL, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL pre_reset_wait: got op=%0d busy=%0b rdy=%0b, expected 2 1 0", fpu_operation, busy, req_ready);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, wb_valid, wb_result, wb_tag, wb_error, busy, fpu_operand_1, fpu_operand_2, fpu_operation}
            !== {1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, FPU_ADD}) begin
            errors++;
            $display("FAIL async_reset: got rdy=%0b v=%0b res=%h tag=%0d err=%0b busy=%0b op=%0d a=%h b=%h, expected 1 0 0 0 0 0 0 0 0",
                     req_ready, wb_valid, wb_result, wb_tag, wb_error, busy, fpu_operation, fpu_operand_1, fpu_operand_2);
        end
        #2 reset = 1'b1;
        fpu_mode = 0;
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wb_valid || busy) saw_valid = 1'b1;
        end
        checks++;
        if ({saw_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_quiet: got activity=%0b rdy=%0b, expected 0 1", saw_valid, req_ready);
        end
    endtask

    task automatic test_coincident();
        int n;
        fpu_mode    = 1;
        fpu_lat     = 8;
        fpu_res_val = 32'h1234_5678;
        drive_req(FPU_SQRT, 32'h100, 32'h0, 5'd12);
        tick();
        req_valid = 1'b0;
        wait_wb(30, n);
        checks++;
        if ({wb_valid, wb_result, wb_tag, wb_error} !== {1'b1, 32'h1234_5678, 5'd12, 1'b0} || n != 10) begin
            errors++;
            $display("FAIL coincident: got v=%0b res=%h tag=%0d err=%0b edges=%0d, expected 1 12345678 12 0 10",
                     wb_valid, wb_result, wb_tag, wb_error, n);
        end
        handshake();
        tick();
    endtask

    task automatic test_back_to_back();
        int          rises [4];
        int          nr;
        int          nw;
        logic [31:0] prev;
        logic [31:0] res [4];
        logic [4:0]  tags [4];
        fpu_mode = 0;
        wb_ready = 1'b1;
        nr = 0;
        nw = 0;
        prev = '0;
        drive_req(FPU_ADD, 32'h1, 32'h2, 5'd11);
        tick();
        drive_req(FPU_ADD, 32'h3, 32'h4, 5'd13);
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) req_valid = 1'b0;
            if (fpu_operand_1 !== 32'h0 && prev === 32'h0 && nr < 4) begin
                rises[nr] = c;
                nr++;
            end
            prev = fpu_operand_1;
            if (wb_valid && nw < 4) begin
                res[nw]  = wb_result;
                tags[nw] = wb_tag;
                nw++;
            end
        end
        wb_ready = 1'b0;
        checks++;
        if (nr != 2 || rises[0] != 1 || rises[1] - rises[0] != 5) begin
            errors++;
            $display("FAIL b2b_spacing: got issues=%0d first=%0d gap=%0d, expected 2 1 5",
                     nr, rises[0], rises[1] - rises[0]);
        end
        checks++;
        if (nw != 2 || {tags[0], res[0], tags[1], res[1]} !== {5'd11, 32'h3, 5'd13, 32'h7}) begin
            errors++;
            $display("FAIL b2b_results: got n=%0d tag0=%0d res0=%h tag1=%0d res1=%h, expected 2 11 00000003 13 00000007",
                     nw, tags[0], res[0], tags[1], res[1]);
        end
        tick();
    endtask

    initial begin
        reset         = 1'b0;
        req_valid     = 1'b0;
        req_op        = FPU_ADD;
        req_operand_1 = '0;
        req_operand_2 = '0;
        req_tag       = '0;
        wb_ready      = 1'b0;
        test_reset();
        test_single_add();
        test_backpressure();
        test_mul_latency();
        test_timeout();
        test_reset_mid_wait();
        test_coincident();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
